// File: rtl/maxpool_pkg.sv
// Shared mode encodings and elaboration/ordering helpers for the pooling tree.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package maxpool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Widest element the ordering key supports.
  localparam int KEY_W = 64;

  // Ceiling log2; 1 for value 2, 4 for value 9.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Number of nodes present at a tree level (level 0 is the raw window).
  function automatic int level_count(input int window, input int level);
    int cnt;
    cnt = window;
    for (int k = 0; k < 32; k++) begin
      if (k < level) cnt = (cnt + 1) / 2;
    end
    return cnt;
  endfunction

  // Node offset of a registered level inside the flat register vector.
  // Registered levels start at level 1, so level 1 sits at offset 0.
  function automatic int node_offset(input int window, input int level);
    int acc;
    acc = 0;
    for (int k = 1; k < 32; k++) begin
      if (k < level) acc += level_count(window, k);
    end
    return acc;
  endfunction

  // Maps a sign-magnitude float onto an unsigned key with the same order:
  // positives get the sign bit set, negatives are fully inverted.
  function automatic logic [KEY_W-1:0] order_key(input logic [KEY_W-1:0] value,
                                                 input int width);
    logic [KEY_W-1:0] mask;
    logic [KEY_W-1:0] sign;
    mask = (KEY_W'(1) << width) - KEY_W'(1);
    sign = KEY_W'(1) << (width - 1);
    if ((value & sign) == '0) return value ^ sign;
    return ~value & mask;
  endfunction

endpackage

// File: rtl/maxpool_cmp.sv
// Two-operand ordered select: larger key in max mode, smaller key in min mode.
// Latency: combinational, registered by the enclosing tree level.
// Backpressure: none, the enclosing tree owns the stall.
module maxpool_cmp import maxpool_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] y
);

  logic [KEY_W-1:0] key_a;
  logic [KEY_W-1:0] key_b;
  logic             take_b;

  assign key_a = order_key(KEY_W'(a), DATA_WIDTH);
  assign key_b = order_key(KEY_W'(b), DATA_WIDTH);

  // Strict compares so that equal keys keep the lower-index operand a.
  always_comb begin
    take_b = 1'b0;
    if (mode == MODE_MIN) take_b = (key_b < key_a);
    else                  take_b = (key_b > key_a);
    y = take_b ? b : a;
  end

endmodule

// File: rtl/maxpool_tree_cell.sv
// Max/min pooling over WINDOW packed float elements via a registered binary tree; MAXPOOL_BYTE_SWAP_EN byte-reverses the result.
// Latency: clog2(WINDOW) cycles from accepted beat to result, one beat per cycle.
// Backpressure: whole pipeline holds when the result is valid and not taken; ready is that enable.
module maxpool_tree_cell import maxpool_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 9
) (
  input  logic                         C_IN_CLK,
  input  logic                         C_IN_RST,
  input  logic                         C_IN_FLUSH,
  input  logic                         C_IN_MODE,
  input  logic                         C_IN_DATA_VALID,
  input  logic [WINDOW*DATA_WIDTH-1:0] D_IN_DATA,
  output logic                         C_OUT_IN_READY,
  input  logic                         C_IN_OUT_READY,
  output logic                         C_OUT_DATA_VALID,
  output logic [DATA_WIDTH-1:0]        C_OUT_DATA
);

  localparam int LEVELS  = clog2(WINDOW);
  localparam int NODES   = node_offset(WINDOW, LEVELS + 1);
  localparam int OUT_OFF = node_offset(WINDOW, LEVELS);
  // Mode is only needed by levels 1..LEVELS-1; keep at least one bit.
  localparam int MD_W    = (LEVELS > 1) ? LEVELS - 1 : 1;

  logic                        en;
  logic [LEVELS-1:0]           vld_q;
  logic [LEVELS-1:0]           lvl_vld_in;
  logic [MD_W-1:0]             md_q;
  logic [MD_W-1:0]             md_nxt;
  logic [NODES*DATA_WIDTH-1:0] node_q;
  logic [NODES*DATA_WIDTH-1:0] node_d;
  logic [DATA_WIDTH-1:0]       res;

  assign C_OUT_DATA_VALID = vld_q[LEVELS-1];
  assign en               = !C_OUT_DATA_VALID || C_IN_OUT_READY;
  assign C_OUT_IN_READY   = en;
  assign res              = node_q[OUT_OFF*DATA_WIDTH +: DATA_WIDTH];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN    = level_count(WINDOW, l);
    localparam int N_OUT   = level_count(WINDOW, l + 1);
    localparam int OFF_OUT = node_offset(WINDOW, l + 1);

    logic [N_IN*DATA_WIDTH-1:0] src;
    logic                       src_md;

    if (l == 0) begin : g_src_in
      assign src           = D_IN_DATA;
      assign src_md        = C_IN_MODE;
      assign lvl_vld_in[0] = C_IN_DATA_VALID;
    end else begin : g_src_q
      localparam int OFF_IN = node_offset(WINDOW, l);
      assign src           = node_q[OFF_IN*DATA_WIDTH +: N_IN*DATA_WIDTH];
      assign src_md        = md_q[l-1];
      assign lvl_vld_in[l] = vld_q[l-1];
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      if (2*j + 1 < N_IN) begin : g_pair
        maxpool_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
          .a    (src[(2*j)*DATA_WIDTH +: DATA_WIDTH]),
          .b    (src[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]),
          .mode (src_md),
          .y    (node_d[(OFF_OUT+j)*DATA_WIDTH +: DATA_WIDTH])
        );
      end else begin : g_pass
        // Odd element out: carried to the next level untouched.
        assign node_d[(OFF_OUT+j)*DATA_WIDTH +: DATA_WIDTH] = src[(2*j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Mode shifts along with its beat so each level compares with the beat's own mode.
  always_comb begin
    md_nxt    = md_q;
    md_nxt[0] = C_IN_MODE;
    for (int k = 1; k < MD_W; k++) md_nxt[k] = md_q[k-1];
  end

  // Stage registers; flush beats the stall, the output slot reads 0 whenever it is empty.
  always_ff @(posedge C_IN_CLK or posedge C_IN_RST) begin
    if (C_IN_RST) begin
      vld_q  <= '0;
      md_q   <= '0;
      node_q <= '0;
    end else if (C_IN_FLUSH) begin
      vld_q                                     <= '0;
      node_q[OUT_OFF*DATA_WIDTH +: DATA_WIDTH] <= '0;
    end else if (en) begin
      vld_q  <= lvl_vld_in;
      md_q   <= md_nxt;
      node_q <= node_d;
      if (!lvl_vld_in[LEVELS-1]) node_q[OUT_OFF*DATA_WIDTH +: DATA_WIDTH] <= '0;
    end
  end

`ifdef MAXPOOL_BYTE_SWAP_EN
  // Byte-reverse the result on its way out.
  always_comb begin
    C_OUT_DATA = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      C_OUT_DATA[i*8 +: 8] = res[DATA_WIDTH-8-i*8 +: 8];
    end
  end
`else
  assign C_OUT_DATA = res;
`endif

endmodule

// File: tb/tb_maxpool_tree_cell.sv
// Bench for maxpool_tree_cell at WINDOW=9, FP32, with a queue scoreboard.
// Latency: expects results 4 cycles after acceptance.
// Backpressure: drives stall windows and random ready on the output side.
module tb_maxpool_tree_cell;

  localparam int W = 32;
  localparam int N = 9;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         flush   = 1'b0;
  logic         mode    = 1'b0;
  logic         in_vld  = 1'b0;
  logic [N*W-1:0] in_dat = '0;
  logic         out_rdy = 1'b1;
  logic         in_rdy;
  logic         out_vld;
  logic [W-1:0] out_dat;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [W-1:0] sb_q[$];
  logic         held_vld = 1'b0;
  logic [W-1:0] held_dat = '0;

  always #5 clk = ~clk;

  maxpool_tree_cell #(.DATA_WIDTH(W), .WINDOW(N)) dut (
    .C_IN_CLK         (clk),
    .C_IN_RST         (rst),
    .C_IN_FLUSH       (flush),
    .C_IN_MODE        (mode),
    .C_IN_DATA_VALID  (in_vld),
    .D_IN_DATA        (in_dat),
    .C_OUT_IN_READY   (in_rdy),
    .C_IN_OUT_READY   (out_rdy),
    .C_OUT_DATA_VALID (out_vld),
    .C_OUT_DATA       (out_dat)
  );

  // True when x orders strictly above y as a float (sign-magnitude view).
  function automatic bit fp_gt(input logic [31:0] x, input logic [31:0] y);
    if (x[31] != y[31]) return (x[31] == 1'b0);
    if (x[31] == 1'b0)  return (x[30:0] > y[30:0]);
    return (x[30:0] < y[30:0]);
  endfunction

  function automatic logic [31:0] pool_ref(input logic [N*W-1:0] d, input logic m);
    logic [31:0] best;
    logic [31:0] c;
    best = d[31:0];
    for (int i = 1; i < N; i++) begin
      c = d[i*W +: W];
      if (m ? fp_gt(best, c) : fp_gt(c, best)) best = c;
    end
    return best;
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] r);
`ifdef MAXPOOL_BYTE_SWAP_EN
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
`else
    return r;
`endif
  endfunction

  function automatic logic [N*W-1:0] rand_beat();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom();
    return d;
  endfunction

  // Scoreboard: pops on output handshake, pushes on input handshake, checks hold/ready rules.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      held_vld = 1'b0;
    end else begin
      checks++;
      if (in_rdy !== (!out_vld || out_rdy)) begin
        failures++;
        $display("FAIL ready_rule got=%b exp=%b", in_rdy, (!out_vld || out_rdy));
      end
      if (out_vld) begin
        if (held_vld) begin
          checks++;
          if (out_dat !== held_dat) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", out_dat, held_dat);
          end
        end
        if (out_rdy) begin
          n_out++;
          held_vld = 1'b0;
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got=%h exp=none", out_dat);
          end else begin
            logic [W-1:0] e;
            e = sb_q.pop_front();
            if (out_dat !== e) begin
              failures++;
              $display("FAIL sb_data got=%h exp=%h", out_dat, e);
            end
          end
        end else begin
          held_vld = 1'b1;
          held_dat = out_dat;
        end
      end else begin
        held_vld = 1'b0;
      end
      if (flush) sb_q.delete();
      else if (in_vld && in_rdy) sb_q.push_back(exp_out(pool_ref(in_dat, mode)));
    end
  end

  task automatic test_reset();
    #2;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_vld); end
    checks++;
    if (out_dat !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_dat); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed_signs();
    int lat;
    in_dat = {32'hC0000000, 32'h3F800000, 32'h40A00000, 32'h00000000, 32'h80000000,
              32'hC0000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
    mode = 1'b0; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 12) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL mixed_latency got=%0d exp=4", lat); end
    checks++;
    if (out_dat !== exp_out(32'h40A00000)) begin
      failures++; $display("FAIL mixed_data got=%h exp=%h", out_dat, exp_out(32'h40A00000));
    end
    @(posedge clk); #1;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL mixed_one_cycle got=%b exp=0", out_vld); end
  endtask

  task automatic test_sign_cases();
    logic [N*W-1:0] tdat[5];
    logic           tmd[5];
    logic [W-1:0]   texp[5];
    int lat;
    tdat[0] = {{8{32'hC0000000}}, 32'hBF800000}; tmd[0] = 1'b0; texp[0] = 32'hBF800000;
    tdat[1] = {{8{32'hC0000000}}, 32'hBF800000}; tmd[1] = 1'b1; texp[1] = 32'hC0000000;
    tdat[2] = {32'h00000000, {8{32'h80000000}}}; tmd[2] = 1'b0; texp[2] = 32'h00000000;
    tdat[3] = {32'h00000000, {8{32'h80000000}}}; tmd[3] = 1'b1; texp[3] = 32'h80000000;
    tdat[4] = {N{32'h3F800000}};                 tmd[4] = 1'b0; texp[4] = 32'h3F800000;
    for (int c = 0; c < 5; c++) begin
      in_dat = tdat[c]; mode = tmd[c]; in_vld = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      lat = 1;
      while (!out_vld && lat < 12) begin @(posedge clk); #1; lat++; end
      checks++;
      if (!out_vld) begin
        failures++; $display("FAIL sign_case%0d_timeout got=invalid exp=valid", c);
      end else if (out_dat !== exp_out(texp[c])) begin
        failures++; $display("FAIL sign_case%0d got=%h exp=%h", c, out_dat, exp_out(texp[c]));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] beats[10];
    logic           mds[10];
    int k, cyc, base, stall_seen;
    logic acc;
    for (int i = 0; i < 10; i++) begin beats[i] = rand_beat(); mds[i] = 1'($urandom_range(0, 1)); end
    k = 0; cyc = 0; stall_seen = 0; base = n_out;
    while (k < 10 && cyc < 40) begin
      out_rdy = !(cyc >= 6 && cyc < 9);
      in_vld = 1'b1; in_dat = beats[k]; mode = mds[k];
      @(negedge clk);
      if (!out_rdy && out_vld) begin
        stall_seen++;
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready got=%b exp=0", in_rdy); end
      end
      acc = in_rdy;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || out_vld) && cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (stall_seen != 3) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stall_seen); end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", sb_q.size()); end
    checks++;
    if (n_out - base != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", n_out - base); end
  endtask

  task automatic test_random();
    int k, cyc, base;
    logic acc;
    k = 0; cyc = 0; base = n_out;
    while (k < 40 && cyc < 400) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      in_vld  = ($urandom_range(0, 4) != 0);
      in_dat  = rand_beat();
      mode    = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || out_vld) && cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (n_out - base != 40) begin failures++; $display("FAIL rand_count got=%0d exp=40", n_out - base); end
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    out_rdy = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_dat = rand_beat();
      @(posedge clk); #1;
    end
    in_dat = rand_beat(); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_vld); end
    checks++;
    if (out_dat !== '0) begin failures++; $display("FAIL flush_data got=%h exp=0", out_dat); end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (out_vld) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL flush_leak got=output exp=none"); end
    in_dat = {32'hC0000000, 32'h3F800000, 32'h40A00000, 32'h00000000, 32'h80000000,
              32'hC0000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 12) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL flush_next_latency got=%0d exp=4", lat); end
    checks++;
    if (out_dat !== exp_out(32'h40A00000)) begin
      failures++; $display("FAIL flush_next_data got=%h exp=%h", out_dat, exp_out(32'h40A00000));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_dat = rand_beat(); mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_vld); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_vld); end
    checks++;
    if (out_dat !== '0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", out_dat); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (out_vld) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL rstmid_leak got=output exp=none"); end
    checks++;
    if (in_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", in_rdy); end
  endtask

  initial begin
    test_reset();
    test_mixed_signs();
    test_sign_cases();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/maxpool_tree_cell.md
MAXPOOL_TREE_CELL -- requirements
Module: maxpool_tree_cell

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning element width; FP32 layout (1 sign, 8 exp, 23 mant) when 32.
REQ-002 SHALL have parameter WINDOW, default 9, meaning number of pooled elements per beat; legal range 2..16.
REQ-003 SHALL have port C_IN_CLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port C_IN_RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port C_IN_FLUSH  input  1  synchronous pipeline clear.
REQ-006 SHALL have port C_IN_MODE  input  1  0 = max pool, 1 = min pool; sampled with the input beat.
REQ-007 SHALL have port C_IN_DATA_VALID  input  1  input beat valid.
REQ-008 SHALL have port D_IN_DATA  input  WINDOW*DATA_WIDTH  packed elements, element i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port C_OUT_IN_READY  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port C_IN_OUT_READY  input  1  downstream accepts output this cycle.
REQ-011 SHALL have port C_OUT_DATA_VALID  output  1  result valid.
REQ-012 SHALL have port C_OUT_DATA  output  DATA_WIDTH  pooled result.

Function
REQ-013 Beat accepted SHALL mean C_IN_DATA_VALID && C_OUT_IN_READY at a rising edge.
REQ-014 Comparison SHALL use ordering key: sign=0 -> flip sign bit; sign=1 -> invert all bits; compare keys unsigned (correct for two negatives; -0.0 < +0.0; NaN ordered by bits, no special case).
REQ-015 Equal keys SHALL select the lower-index operand.
REQ-016 Reduction SHALL be a binary tree of LEVELS = clog2(WINDOW) registered stages; unpaired odd element SHALL pass through registered unchanged.
REQ-017 Latency SHALL be exactly LEVELS cycles from accepted beat to C_OUT_DATA_VALID when unstalled (WINDOW=9 -> 4; WINDOW=2 -> 1).
REQ-018 Throughput SHALL be one beat per cycle when C_IN_OUT_READY=1.
REQ-019 Each stage SHALL carry a valid bit and the beat's mode; mode SHALL not change for a beat in flight.
REQ-020 Pipeline advance enable SHALL be !C_OUT_DATA_VALID || C_IN_OUT_READY; C_OUT_IN_READY SHALL equal this enable (combinational).
REQ-021 When stalled, all stage registers and C_OUT_DATA SHALL hold; C_OUT_DATA SHALL not change while C_OUT_DATA_VALID=1 and C_IN_OUT_READY=0.
REQ-022 Internal bubbles SHALL advance only with the global enable (no bubble collapsing).
REQ-023 C_IN_FLUSH=1 SHALL clear all stage valids and C_OUT_DATA_VALID on the next edge regardless of stall; a beat presented in the same cycle SHALL be dropped.
REQ-024 C_OUT_DATA SHALL be 0 whenever C_OUT_DATA_VALID=0 after reset or flush until the next result.

Reset
REQ-025 C_IN_RST=1 SHALL immediately clear all stage valids, C_OUT_DATA_VALID=0, C_OUT_DATA=0; data registers SHALL reset to 0.
REQ-026 After reset release C_OUT_IN_READY SHALL be 1; reset mid-operation SHALL discard all in-flight beats with no output produced.

Configuration
REQ-027 With macro MAXPOOL_BYTE_SWAP_EN defined, C_OUT_DATA SHALL be the result with byte order reversed (byte 0 <-> byte N-1, DATA_WIDTH multiple of 8); without it, C_OUT_DATA SHALL be the result in natural order.

Structure
REQ-028 Package maxpool_pkg SHALL hold the mode encoding constants (MODE_MAX=0, MODE_MIN=1), the clog2 function and the ordering-key function.
REQ-029 One sub-module maxpool_cmp SHALL implement the two-operand key compare/select with mode; the tree SHALL be generated from it.

Verification
REQ-030 Mixed signs, mode 0, WINDOW=9: {3F800000,40000000,BF800000,C0000000,80000000,00000000,40A00000,3F800000,C0000000} -> 40A00000 after 4 cycles, valid one cycle.
REQ-031 All negative, mode 0: {BF800000,C0000000 x8} -> BF800000; mode 1 same beat -> C0000000.
REQ-032 Zero signs: mode 0 {80000000 x8, 00000000} -> 00000000; mode 1 -> 80000000.
REQ-033 Back-to-back 10 beats with C_IN_OUT_READY held 0 from cycle 6 for 3 cycles -> C_OUT_IN_READY low during stall, no output lost/duplicated, held data stable, order preserved.
REQ-034 Flush with 3 beats in flight plus a beat on the flush cycle -> no outputs; next beat emerges after 4 cycles; reset asserted mid-stream -> outputs 0/invalid immediately.
REQ-035 Build with and without MAXPOOL_BYTE_SWAP_EN: result 3F800000 -> C_OUT_DATA 0000803F vs 3F800000.
